// File: rtl/attn_pkg.sv
// Shared definitions for the attention sequencer: instruction bit map,
// counter width and the controller state encoding.
package attn_pkg;

    localparam int INST_W = 19;
    localparam int CNT_W  = 4;

    localparam int BIT_QMEM_WR  = 0;
    localparam int BIT_QMEM_RD  = 1;
    localparam int BIT_KMEM_WR  = 2;
    localparam int BIT_KMEM_RD  = 3;
    localparam int BIT_LOAD     = 4;
    localparam int BIT_EXECUTE  = 5;
    localparam int BIT_OFIFO_RD = 6;
    localparam int BIT_PMEM_WR  = 7;
    localparam int BIT_PMEM_RD  = 8;
    localparam int BIT_NORM     = 9;
    localparam int QK_ADDR_LSB  = 11;
    localparam int P_ADDR_LSB   = 15;

    typedef enum logic [3:0] {
        IDLE, WR_Q, WR_K, LOAD, GAP, EXEC, DRAIN, OUT, NORM, FIN
    } state_e;

endpackage

// File: rtl/seq_cnt.sv
// Step counter shared by all sequencer phases; saturates at its terminal
// value so a missed clear can never wrap an address.
module seq_cnt
    import attn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc  = (cnt_q == term);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/attn_seq_ctrl.sv
// Q.K pass sequencer: streams host vectors into q/k memories, then walks the
// core through load, execute, drain, psum store and normalize.
//
// state | meaning
// IDLE  | waiting for start; num_q==0 pulses err
// WR_Q  | accept nq Q rows from host into qmem
// WR_K  | accept col K rows from host into kmem
// LOAD  | col cycles of kmem_rd|load into the array
// GAP   | one bubble between load and execute
// EXEC  | nq cycles of qmem_rd|execute
// DRAIN | DRAIN_CYC idle cycles for the array pipeline to empty
// OUT   | nq cycles of ofifo_rd|pmem_wr
// NORM  | nq cycles of pmem_rd|norm
// FIN   | done pulse, back to IDLE
module attn_seq_ctrl
    import attn_pkg::*;
#(
    parameter int col       = 8,
    parameter int bw        = 8,
    parameter int pr        = 16,
    parameter int DRAIN_CYC = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        num_q,
    input  logic [pr*bw-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [pr*bw-1:0]  mem_in,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] COL_TC   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] DRAIN_TC = CNT_W'(DRAIN_CYC - 1);

    state_e             state_q, state_d;
    logic [3:0]         nq_q, nq_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [pr*bw-1:0]   mem_in_q, mem_in_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cnt_clr, cnt_en, cnt_tc, accept;
    logic [CNT_W-1:0]   cnt, term;
    logic [CNT_W-1:0]   nq_tc;

    seq_cnt u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (term),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    assign accept = in_valid && in_ready_q;
    assign nq_tc  = nq_q - 4'd1;

    always_comb begin
        state_d  = state_q;
        nq_d     = nq_q;
        inst_d   = '0;
        mem_in_d = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_en   = 1'b1;
        term     = '0;
        unique case (state_q)
            IDLE: begin
                cnt_en = 1'b0;
                if (start) begin
                    if (num_q != 4'd0) begin
                        nq_d    = num_q;
                        state_d = WR_Q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_Q, WR_K: begin
                term   = (state_q == WR_Q) ? nq_tc : COL_TC;
                cnt_en = accept;
                if (accept) begin
                    inst_d[(state_q == WR_Q) ? BIT_QMEM_WR : BIT_KMEM_WR] = 1'b1;
                    inst_d[QK_ADDR_LSB +: CNT_W] = cnt;
                    mem_in_d = in_data;
                    if (cnt_tc) state_d = (state_q == WR_Q) ? WR_K : LOAD;
                end
            end
            LOAD: begin
                term = COL_TC;
                inst_d[BIT_KMEM_RD] = 1'b1;
                inst_d[BIT_LOAD]    = 1'b1;
                inst_d[QK_ADDR_LSB +: CNT_W] = cnt;
                if (cnt_tc) state_d = GAP;
            end
            GAP: state_d = EXEC;
            EXEC: begin
                term = nq_tc;
                inst_d[BIT_QMEM_RD] = 1'b1;
                inst_d[BIT_EXECUTE] = 1'b1;
                inst_d[QK_ADDR_LSB +: CNT_W] = cnt;
                if (cnt_tc) state_d = DRAIN;
            end
            DRAIN: begin
                term = DRAIN_TC;
                if (cnt_tc) state_d = OUT;
            end
            OUT: begin
                term = nq_tc;
                inst_d[BIT_OFIFO_RD] = 1'b1;
                inst_d[BIT_PMEM_WR]  = 1'b1;
                inst_d[P_ADDR_LSB +: CNT_W] = cnt;
                if (cnt_tc) state_d = NORM;
            end
            NORM: begin
                term = nq_tc;
                inst_d[BIT_PMEM_RD] = 1'b1;
                inst_d[BIT_NORM]    = 1'b1;
                inst_d[P_ADDR_LSB +: CNT_W] = cnt;
                if (cnt_tc) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cnt_clr    = (state_d != state_q);
        in_ready_d = (state_d == WR_Q) || (state_d == WR_K);
        busy_d     = (state_q != IDLE);
    end

    // Outputs describe the action of the current state, so they trail state_q
    // by one edge; busy and done trail identically and stay aligned with inst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            nq_q       <= '0;
            inst_q     <= '0;
            mem_in_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nq_q       <= nq_d;
            inst_q     <= inst_d;
            mem_in_q   <= mem_in_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign inst     = inst_q;
    assign mem_in   = mem_in_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Scoreboard bench for attn_seq_ctrl: each pass pushes its expected
// instruction stream; a monitor pops one entry per busy cycle.
module tb_attn_seq_ctrl;

    localparam int DW = 128;

    typedef struct {
        logic [18:0]   inst;
        logic [DW-1:0] mem;
        logic          done;
    } exp_t;

    logic          clk, reset, start, in_valid, in_ready, busy, done, err;
    logic [3:0]    num_q;
    logic [DW-1:0] in_data, mem_in;
    logic [18:0]   inst;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    bit   stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    attn_seq_ctrl #(.col(8), .bw(8), .pr(16), .DRAIN_CYC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .num_q(num_q),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_in(mem_in), .inst(inst), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] vec(input int b);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(b) * 32'h0101;
        return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(b)};
    endfunction

    function automatic void push(input logic [18:0] i, input logic [DW-1:0] m, input logic d);
        exp_t e;
        e.inst = i; e.mem = m; e.done = d;
        exp_q.push_back(e);
    endfunction

    function automatic bit vld_at(input int idx, input bit stall);
        return (stall && idx < 4) ? stall_pat[idx] : 1'b1;
    endfunction

    // expected core stream for one pass, from the instruction field map
    task automatic build_exp(input int n, input bit stall);
        int acc, idx;
        acc = 0; idx = 0;
        while (acc < n) begin
            if (vld_at(idx, stall)) begin push(19'h001 | 19'(acc << 11), vec(acc), 0); acc++; end
            else push(0, 0, 0);
            idx++;
        end
        acc = 0;
        while (acc < 8) begin
            if (vld_at(idx, stall)) begin push(19'h004 | 19'(acc << 11), vec(n + acc), 0); acc++; end
            else push(0, 0, 0);
            idx++;
        end
        for (int i = 0; i < 8; i++)  push(19'h018 | 19'(i << 11), 0, 0);
        push(0, 0, 0);
        for (int i = 0; i < n; i++)  push(19'h022 | 19'(i << 11), 0, 0);
        for (int i = 0; i < 10; i++) push(0, 0, 0);
        for (int i = 0; i < n; i++)  push(19'h0C0 | 19'(i << 15), 0, 0);
        for (int i = 0; i < n; i++)  push(19'h300 | 19'(i << 15), 0, 0);
        push(0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (!reset && busy) begin
            busy_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL exp_underflow: got busy cycle with inst %0h, expected idle", inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("inst", DW'(inst), DW'(e.inst));
                chk("mem_in", mem_in, e.mem);
                chk("done", DW'(done), DW'(e.done));
            end
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; num_q = 4'(n);
        @(negedge clk);
        start = 1'b0; num_q = 4'd0;
    endtask

    task automatic feed(input int n, input bit stall);
        int  beat, idx, guard;
        bit  acc;
        beat = 0; idx = 0; guard = 0;
        while (beat < n + 8 && guard < 300) begin
            in_valid = vld_at(idx, stall);
            in_data  = vec(beat);
            acc      = in_ready && in_valid;
            @(negedge clk);
            if (acc) beat++;
            idx++; guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("feed_complete", DW'(beat), DW'(n + 8));
    endtask

    task automatic wait_done(input int exp_busy);
        int g;
        g = 0;
        while (!done && g < 300) begin @(negedge clk); g++; end
        chk("done_seen", DW'(done), 1);
        @(negedge clk);
        chk("busy_drop", DW'(busy), 0);
        chk("done_one_cycle", DW'(done), 0);
        chk("queue_empty", DW'(exp_q.size()), 0);
        chk("busy_cycles", DW'(busy_cnt), DW'(exp_busy));
    endtask

    task automatic wait_exec();
        int g;
        g = 0;
        while (!inst[5] && g < 200) begin @(negedge clk); g++; end
        chk("exec_seen", DW'(inst[5]), 1);
    endtask

    initial begin
        bit seen_bad;
        reset = 1'b1; start = 1'b0; num_q = 4'd0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_inst", DW'(inst), 0);
        chk("rst_mem_in", mem_in, 0);
        chk("rst_in_ready", DW'(in_ready), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_done", DW'(done), 0);
        chk("rst_err", DW'(err), 0);
        reset = 1'b0;

        // num_q = 0 is rejected
        do_start(0);
        chk("zero_err", DW'(err), 1);
        chk("zero_busy", DW'(busy), 0);
        chk("zero_inst", DW'(inst), 0);
        @(negedge clk);
        chk("zero_err_pulse", DW'(err), 0);
        chk("zero_busy_after", DW'(busy), 0);

        // basic pass, nq=2, no stalls
        busy_cnt = 0; build_exp(2, 0);
        do_start(2); feed(2, 0); wait_done(36);

        // host stalls 1,0,0,1 in WR_Q
        busy_cnt = 0; build_exp(2, 1);
        do_start(2); feed(2, 1); wait_done(38);

        // start during EXEC is ignored
        busy_cnt = 0; build_exp(2, 0);
        do_start(2); feed(2, 0); wait_exec();
        start = 1'b1; num_q = 4'd5;
        repeat (3) @(negedge clk);
        start = 1'b0; num_q = 4'd0;
        wait_done(36);

        // reset during DRAIN aborts the pass
        busy_cnt = 0; build_exp(2, 0);
        do_start(2); feed(2, 0); wait_exec();
        while (inst[5]) @(negedge clk);
        chk("in_drain", DW'(busy && inst == 0), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_inst", DW'(inst), 0);
        chk("abort_busy", DW'(busy), 0);
        chk("abort_in_ready", DW'(in_ready), 0);
        chk("abort_done", DW'(done), 0);
        exp_q.delete();
        seen_bad = 1'b0;
        repeat (20) begin @(negedge clk); if (done || busy) seen_bad = 1'b1; end
        chk("no_done_after_abort", DW'(seen_bad), 0);
        busy_cnt = 0; build_exp(1, 0);
        do_start(1); feed(1, 0); wait_done(32);

        // maximum depth
        busy_cnt = 0; build_exp(15, 0);
        do_start(15); feed(15, 0); wait_done(88);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
